decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, parametrised decode stage sitting between fetch and execute.
- Extracts register indices from the raw instruction and reads the register file combinationally.
- Resolves operands against NUM_FWD prioritised forwarding sources and detects load-use hazards.
- Holds the decoded operand bundle in an ID/EX output register with valid/ready handshakes on both sides, plus flush support.

Parameters:
XLEN, 64, operand/data width in bits
NUM_FWD, 3, number of forwarding sources; index 0 = youngest (highest priority)
REG_AW, 5, register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
in_pc  in  XLEN  instruction PC
in_instr  in  32  raw instruction
ra1  out  REG_AW  regfile read address 1 = in_instr[19:15]
ra2  out  REG_AW  regfile read address 2 = in_instr[24:20]
rd1  in  XLEN  regfile read data 1 (combinational)
rd2  in  XLEN  regfile read data 2 (combinational)
fwd_valid  in  NUM_FWD  source i holds a live destination write
fwd_dst  in  NUM_FWD*REG_AW  destination index of source i (slice i)
fwd_data  in  NUM_FWD*XLEN  result of source i (slice i)
fwd_pending  in  NUM_FWD  source i result not yet available (load in flight)
flush  in  1  squash the held and incoming instruction
out_valid  out  1  ID/EX register holds a valid instruction
out_ready  in  1  execute consumes the bundle
out_pc  out  XLEN  registered PC
out_instr  out  32  registered raw instruction
out_rs1  out  REG_AW  registered rs1
out_rs2  out  REG_AW  registered rs2
out_dst  out  REG_AW  registered rd = in_instr[11:7]
out_srca  out  XLEN  registered resolved operand A
out_srcb  out  XLEN  registered resolved operand B
hazard  out  1  load-use stall asserted this cycle (combinational)

Behaviour:
- Reset (reset low, async): out_valid=0; all out_* data registers = 0. hazard and in_ready derive combinationally from the cleared state.
- Operand resolution (combinational), per operand with index r:
  - r==0: value 0; never forwarded, never hazards.
  - Otherwise scan i = 0..NUM_FWD-1 and take the first i with fwd_valid[i] && fwd_dst[i]==r.
  - Match found and fwd_pending[i]=0: operand = fwd_data[i].
  - Match found and fwd_pending[i]=1: operand hazard.
  - No match: operand = rd1/rd2.
  - Older matching sources are ignored once a younger one matches, even if an older one is pending.
- hazard = in_valid && (hazard on rs1 || hazard on rs2). Both raw fields are checked for every opcode; conservative stalls on I/U/J types are accepted.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Accept: in_valid && in_ready. The output register loads pc, instr, rs1, rs2, dst and the resolved operands. out_valid=1 next cycle. Latency is 1 cycle.
- No accept and out_ready && out_valid: out_valid=0 next cycle (bubble).
- Stall by out_ready=0: all out_* hold stable, and out_valid stays 1.
- flush=1: out_valid=0 next cycle. The incoming instruction is not accepted. Flush overrides accept and hold.
- Data registers update only on accept. Their contents are don't-care while out_valid=0.
- Simultaneous out_ready and accept: the new bundle replaces the old in the same edge (full throughput).
- Reset asserted mid-operation clears out_valid immediately, regardless of clk.

Optional Feature:
DECODE_STALL_CNT_EN
- Defined:
  - Adds output port stall_cycles, 32 bits.
  - Counts cycles with hazard=1, plus cycles with out_valid && !out_ready.
  - Increments by 1 per qualifying cycle and saturates at 0xFFFFFFFF.
  - Cleared by reset. Flush does not clear it.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Reset then idle: reset low, 3 cycles -> out_valid=0, out_srca=0, in_ready=1 after release.
- Regfile path: instr add x3,x1,x2 (0x002081B3), rd1=5, rd2=7, no fwd -> next cycle out_valid=1, out_srca=5, out_srcb=7, out_dst=3.
- Forward priority: rs1=x1, fwd_valid=3'b011, fwd_dst[0]=1 data 0xAA, fwd_dst[1]=1 data 0xBB -> out_srca=0xAA. Same with rs1=x0 -> out_srca=0.
- Load-use: fwd_valid[0]=1, fwd_dst[0]=2, fwd_pending[0]=1, instr reads x2 -> hazard=1, in_ready=0, out_valid drops after drain. Clear pending with data 0x55 -> accepted, out_srcb=0x55.
- Backpressure/flush: out_ready=0 for 4 cycles -> outputs stable. Then flush=1 -> out_valid=0 next cycle, and the flush-cycle instruction is never emitted.
- With DECODE_STALL_CNT_EN: 4 backpressure cycles plus 2 hazard cycles -> stall_cycles=6.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode stage: regfile read, prioritised forwarding, load-use hazard, ID/EX register
// Optional feature macro: DECODE_STALL_CNT_EN adds the 32-bit stall_cycles counter port.
module decode_stage #(
   parameter int XLEN    = 64,
   parameter int NUM_FWD = 3,
   parameter int REG_AW  = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [XLEN-1:0]           in_pc,
   input  logic [31:0]               in_instr,
   output logic [REG_AW-1:0]         ra1,
   output logic [REG_AW-1:0]         ra2,
   input  logic [XLEN-1:0]           rd1,
   input  logic [XLEN-1:0]           rd2,
   input  logic [NUM_FWD-1:0]        fwd_valid,
   input  logic [NUM_FWD*REG_AW-1:0] fwd_dst,
   input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
   input  logic [NUM_FWD-1:0]        fwd_pending,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [XLEN-1:0]           out_pc,
   output logic [31:0]               out_instr,
   output logic [REG_AW-1:0]         out_rs1,
   output logic [REG_AW-1:0]         out_rs2,
   output logic [REG_AW-1:0]         out_dst,
   output logic [XLEN-1:0]           out_srca,
   output logic [XLEN-1:0]           out_srcb,
   output logic                      hazard
`ifdef DECODE_STALL_CNT_EN
   ,
   output logic [31:0]               stall_cycles
`endif
);

   logic [REG_AW-1:0] rs1, rs2, dst;
   logic [XLEN-1:0]   srca, srcb;
   logic              haz_a, haz_b;
   logic              accept;

   assign rs1 = in_instr[15 +: REG_AW];
   assign rs2 = in_instr[20 +: REG_AW];
   assign dst = in_instr[7 +: REG_AW];
   assign ra1 = rs1;
   assign ra2 = rs2;

   // Returns {hazard, operand}. Walks oldest to youngest so the youngest match sticks.
   function automatic logic [XLEN:0] resolve(input logic [REG_AW-1:0] r,
                                             input logic [XLEN-1:0]   rf);
      logic [XLEN:0] res;
      res = {1'b0, rf};
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (fwd_valid[i] && (fwd_dst[i*REG_AW +: REG_AW] == r))
            res = {fwd_pending[i], fwd_data[i*XLEN +: XLEN]};
      end
      if (r == '0)
         res = '0;
      return res;
   endfunction

   always_comb begin
      {haz_a, srca} = resolve(rs1, rd1);
      {haz_b, srcb} = resolve(rs2, rd2);
   end

   assign hazard   = in_valid && (haz_a || haz_b);
   assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_pc    <= '0;
         out_instr <= '0;
         out_rs1   <= '0;
         out_rs2   <= '0;
         out_dst   <= '0;
         out_srca  <= '0;
         out_srcb  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_pc    <= in_pc;
         out_instr <= in_instr;
         out_rs1   <= rs1;
         out_rs2   <= rs2;
         out_dst   <= dst;
         out_srca  <= srca;
         out_srcb  <= srcb;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef DECODE_STALL_CNT_EN
   // A cycle that is both a hazard and a backpressure stall counts once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_cycles <= '0;
      else if ((hazard || (out_valid && !out_ready)) && (stall_cycles != '1))
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage: vector table, directed sequences, random vs model
module tb_decode_stage;
   localparam int NF = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_pc = '0;
   logic [31:0] in_instr = '0;
   logic [4:0]  ra1, ra2;
   logic [63:0] rd1 = '0, rd2 = '0;
   logic [2:0]  fwd_valid = '0, fwd_pending = '0;
   logic [4:0]  m_dst [NF];
   logic [63:0] m_data [NF];
   logic [14:0] fwd_dst;
   logic [191:0] fwd_data;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_pc, out_srca, out_srcb;
   logic [31:0] out_instr;
   logic [4:0]  out_rs1, out_rs2, out_dst;
   logic        hazard;
`ifdef DECODE_STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif

   assign fwd_dst  = {m_dst[2], m_dst[1], m_dst[0]};
   assign fwd_data = {m_data[2], m_data[1], m_data[0]};

   decode_stage dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data), .fwd_pending(fwd_pending),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_dst(out_dst), .out_srca(out_srca), .out_srcb(out_srcb), .hazard(hazard)
`ifdef DECODE_STALL_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] r1, r2;
      logic [2:0]  fv, fp;
      logic [4:0]  d0, d1, d2;
      logic [63:0] x0, x1, x2;
      logic        ehaz;
      logic [63:0] ea, eb;
   } vec_t;
   vec_t vt [8];

   logic [31:0]  w;
   logic [64:0]  oa, ob;
   logic         e_haz, e_rdy, m_ov;
   logic [238:0] m_bundle;
   logic [31:0]  m_cnt;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
      return {7'd0, r2, r1, 3'd0, rd, 7'h33};
   endfunction

   // Youngest live source naming r wins; result {hazard, value}.
   function automatic logic [64:0] ref_op(input logic [4:0] r, input logic [63:0] rf);
      int hits[$];
      if (r == 5'd0) return 65'd0;
      for (int i = 0; i < NF; i++)
         if (fwd_valid[i] && m_dst[i] == r) hits.push_back(i);
      if (hits.size() == 0) return {1'b0, rf};
      if (fwd_pending[hits[0]]) return {1'b1, 64'd0};
      return {1'b0, m_data[hits[0]]};
   endfunction

   task automatic clear_fwd;
      fwd_valid = '0;
      fwd_pending = '0;
      for (int i = 0; i < NF; i++) begin
         m_dst[i] = '0;
         m_data[i] = '0;
      end
   endtask

   initial begin
      clear_fwd();
      vt[0] = '{32'h002081B3, 64'd5, 64'd7, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0,
                64'd0, 64'd0, 64'd0, 1'b0, 64'd5, 64'd7};
      vt[1] = '{mk(1, 2, 4), 64'd1, 64'd2, 3'b011, 3'b000, 5'd1, 5'd1, 5'd0,
                64'hAA, 64'hBB, 64'd0, 1'b0, 64'hAA, 64'd2};
      vt[2] = '{mk(0, 2, 4), 64'd5, 64'd2, 3'b011, 3'b000, 5'd0, 5'd0, 5'd0,
                64'hAA, 64'hBB, 64'd0, 1'b0, 64'd0, 64'd2};
      vt[3] = '{mk(3, 2, 5), 64'd3, 64'd2, 3'b001, 3'b001, 5'd2, 5'd0, 5'd0,
                64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 64'd0};
      vt[4] = '{mk(6, 7, 1), 64'd6, 64'd7, 3'b111, 3'b010, 5'd6, 5'd6, 5'd7,
                64'h11, 64'h22, 64'h33, 1'b0, 64'h11, 64'h33};
      vt[5] = '{mk(9, 9, 2), 64'd9, 64'd9, 3'b110, 3'b001, 5'd9, 5'd9, 5'd9,
                64'h55, 64'h66, 64'h77, 1'b0, 64'h66, 64'h66};
      vt[6] = '{mk(8, 0, 3), 64'd8, 64'd1, 3'b100, 3'b100, 5'd0, 5'd0, 5'd8,
                64'd0, 64'd0, 64'h44, 1'b1, 64'd0, 64'd0};
      vt[7] = '{mk(0, 0, 1), 64'h123, 64'h456, 3'b001, 3'b001, 5'd0, 5'd0, 5'd0,
                64'h9, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0};

      // Reset then idle
      repeat (3) begin
         step();
         chk("rst_out_valid", out_valid, 1'b0);
         chk("rst_out_srca", out_srca, 64'd0);
      end
      reset = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1'b1);

      // Backpressure then flush
      in_valid = 1'b1; in_instr = mk(1, 2, 3); in_pc = 64'h100; rd1 = 64'h11; rd2 = 64'h22;
      out_ready = 1'b1;
      step();
      chk("bp_accept_valid", out_valid, 1'b1);
      chk("bp_accept_srca", out_srca, 64'h11);
      in_instr = mk(4, 5, 6); in_pc = 64'h200; rd1 = 64'h44; out_ready = 1'b0;
      repeat (4) begin
         #1;
         chk("bp_in_ready", in_ready, 1'b0);
         step();
         chk("bp_out_valid", out_valid, 1'b1);
         chk("bp_hold", {out_pc, out_instr, out_srca, out_srcb}, {64'h100, mk(1, 2, 3), 64'h11, 64'h22});
      end
      flush = 1'b1; out_ready = 1'b1;
      #1;
      chk("flush_in_ready", in_ready, 1'b0);
      step();
      chk("flush_out_valid", out_valid, 1'b0);
      flush = 1'b0; in_valid = 1'b0;
      repeat (3) begin
         step();
         chk("flush_no_emit", out_valid, 1'b0);
      end

      // Load-use stall, then release with the loaded value
      in_valid = 1'b1; in_instr = mk(3, 2, 5); rd2 = 64'h99;
      fwd_valid = 3'b001; m_dst[0] = 5'd2; fwd_pending = 3'b001;
      #1;
      chk("lu_hazard", hazard, 1'b1);
      chk("lu_in_ready", in_ready, 1'b0);
      step();
      step();
      chk("lu_out_valid", out_valid, 1'b0);
      fwd_pending = 3'b000; m_data[0] = 64'h55;
      #1;
      chk("lu_clear_hazard", hazard, 1'b0);
      chk("lu_clear_in_ready", in_ready, 1'b1);
      step();
      chk("lu_accept_valid", out_valid, 1'b1);
      chk("lu_srcb", out_srcb, 64'h55);
`ifdef DECODE_STALL_CNT_EN
      chk("stall_cycles", stall_cycles, 32'd6);
`endif
      in_valid = 1'b0;

      // Asynchronous reset between clock edges
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 1'b0);
      chk("async_rst_pc", out_pc, 64'd0);
      step();
      reset = 1'b1;
      clear_fwd();

      // Vector table
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1; in_instr = vt[k].instr; in_pc = 64'h1000 + 64'(k * 4);
         rd1 = vt[k].r1; rd2 = vt[k].r2;
         fwd_valid = vt[k].fv; fwd_pending = vt[k].fp;
         m_dst[0] = vt[k].d0; m_dst[1] = vt[k].d1; m_dst[2] = vt[k].d2;
         m_data[0] = vt[k].x0; m_data[1] = vt[k].x1; m_data[2] = vt[k].x2;
         #1;
         chk("vec_hazard", hazard, vt[k].ehaz);
         chk("vec_ra", {ra1, ra2}, {vt[k].instr[19:15], vt[k].instr[24:20]});
         step();
         if (vt[k].ehaz) begin
            chk("vec_bubble", out_valid, 1'b0);
         end else begin
            chk("vec_out_valid", out_valid, 1'b1);
            chk("vec_operands", {out_srca, out_srcb}, {vt[k].ea, vt[k].eb});
            chk("vec_dst_pc", {out_dst, out_pc}, {vt[k].instr[11:7], 64'h1000 + 64'(k * 4)});
         end
      end

      // Randomized traffic against the reference model
      in_valid = 1'b0; clear_fwd();
      reset = 1'b0;
      step();
      reset = 1'b1;
      m_ov = 1'b0; m_bundle = '0; m_cnt = '0;
      for (int n = 0; n < 600; n++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         flush     = ($urandom_range(15) == 0);
         w = $urandom;
         w[19:15] = 5'($urandom_range(3));
         w[24:20] = 5'($urandom_range(3));
         in_instr = w;
         in_pc = {$urandom, $urandom};
         rd1 = {$urandom, $urandom};
         rd2 = {$urandom, $urandom};
         for (int i = 0; i < NF; i++) begin
            fwd_valid[i]   = 1'($urandom_range(1));
            fwd_pending[i] = ($urandom_range(3) == 0);
            m_dst[i]       = 5'($urandom_range(3));
            m_data[i]      = {$urandom, $urandom};
         end
         #1;
         oa = ref_op(w[19:15], rd1);
         ob = ref_op(w[24:20], rd2);
         e_haz = in_valid && (oa[64] || ob[64]);
         e_rdy = (!m_ov || out_ready) && !e_haz && !flush;
         chk("rnd_hazard", hazard, e_haz);
         chk("rnd_in_ready", in_ready, e_rdy);
         if ((e_haz || (m_ov && !out_ready)) && m_cnt != 32'hFFFF_FFFF)
            m_cnt = m_cnt + 1;
         if (flush)
            m_ov = 1'b0;
         else if (in_valid && e_rdy) begin
            m_ov = 1'b1;
            m_bundle = {in_pc, w, w[19:15], w[24:20], w[11:7], oa[63:0], ob[63:0]};
         end else if (out_ready)
            m_ov = 1'b0;
         step();
         chk("rnd_out_valid", out_valid, m_ov);
         if (m_ov)
            chk("rnd_bundle", {out_pc, out_instr, out_rs1, out_rs2, out_dst, out_srca, out_srcb}, m_bundle);
      end
`ifdef DECODE_STALL_CNT_EN
      chk("rnd_stall_cycles", stall_cycles, m_cnt);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
